// File: rtl/word_packer_pkg.sv
// Shared sizing and types for the byte-to-word packer.
// The word layout is MSB-first: byte 0 of a word lands in the top lane.
package packer_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 8;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    // Needs to hold WORD_BYTES itself, so one more than the lane count.
    localparam int CNT_W      = $clog2(WORD_BYTES + 1);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/word_packer_if.sv
// Byte-in / word-out port bundle of the packer.
// The slave modport is the packer; the master modport is its environment.
interface word_packer_if;
    import packer_pkg::*;

    logic  validIn;
    byte_t inData8;
    logic  readyIn;
    logic  flush;
    logic  validOut;
    word_t outData;
    cnt_t  outCount;
    logic  readyOut;

    modport slave (
        input  validIn, inData8, flush, readyOut,
        output readyIn, validOut, outData, outCount
    );

    modport master (
        output validIn, inData8, flush, readyOut,
        input  readyIn, validOut, outData, outCount
    );

endinterface

// File: rtl/word_packer_out_skid_reg.sv
// One-entry valid/ready holding register for finished words.
// A load on the same edge as a drain replaces the drained entry.
module out_skid_reg
    import packer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  word_t load_data,
    input  cnt_t  load_count,
    input  logic  ready,
    output logic  can_load,
    output logic  valid,
    output word_t data,
    output cnt_t  count
);

    logic  valid_q, valid_d;
    word_t data_q, data_d;
    cnt_t  count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            count_d = load_count;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign can_load = !valid_q || ready;
    assign valid    = valid_q;
    assign data     = data_q;
    assign count    = count_q;

endmodule

// File: rtl/word_packer.sv
// Reassembles a byte stream into 64-bit words, first byte in the top lane.
// A flush emits a zero-padded partial word together with its byte count.
module word_packer
    import packer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    word_packer_if.slave  bus
);

    // cnt_q == WORD_BYTES is the "accumulator full, waiting to move" state.
    word_t acc_q, acc_d;
    cnt_t  cnt_q, cnt_d;
    logic  pend_flush_q, pend_flush_d;

    word_t acc_n;
    cnt_t  cnt_n;
    logic  ready_in;
    logic  accept;
    logic  word_done;
    logic  emit;
    logic  load;
    logic  can_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            pend_flush_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    assign ready_in = (cnt_q != cnt_t'(WORD_BYTES)) && !pend_flush_q;
    assign accept   = bus.validIn && ready_in;

    always_comb begin
        acc_n = acc_q;
        cnt_n = cnt_q;
        if (accept) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (cnt_q == cnt_t'(WORD_BYTES - 1 - i)) begin
                    acc_n[i*BYTE_W +: BYTE_W] = bus.inData8;
                end
            end
            cnt_n = cnt_q + cnt_t'(1);
        end
    end

    // A full word always wants out; a partial one only when flushed, now or earlier.
    always_comb begin
        word_done    = (cnt_n == cnt_t'(WORD_BYTES));
        emit         = word_done || ((bus.flush || pend_flush_q) && (cnt_n != '0));
        load         = emit && can_load;
        acc_d        = acc_n;
        cnt_d        = cnt_n;
        pend_flush_d = emit && !word_done;
        if (load) begin
            acc_d        = '0;
            cnt_d        = '0;
            pend_flush_d = 1'b0;
        end
    end

    out_skid_reg u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (acc_n),
        .load_count (cnt_n),
        .ready      (bus.readyOut),
        .can_load   (can_load),
        .valid      (bus.validOut),
        .data       (bus.outData),
        .count      (bus.outCount)
    );

    assign bus.readyIn = ready_in;

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Receive-side counterpart of the DataProcessing 64-to-8 serializer.
- Accepts a byte stream (validIn/inData8) and reassembles it into 64-bit words, first byte received into the most-significant byte.
- Output is a valid/ready port, so downstream can stall. A flush input emits a zero-padded partial word with its byte count.

Parameters:
- BYTE_W, 8, bits per input byte.
- WORD_BYTES, 8, bytes per output word; output width is BYTE_W*WORD_BYTES = 64.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- validIn  in  1  inData8 carries a byte this cycle.
- inData8  in  BYTE_W  input byte.
- readyIn  out  1  packer accepts a byte this cycle; a byte transfers when validIn && readyIn.
- flush  in  1  single-cycle request to emit the current partial word.
- validOut  out  1  outData/outCount hold a word.
- outData  out  64  packed word; first byte at [63:56].
- outCount  out  4  valid bytes in outData (1..8); 8 for a full word.
- readyOut  in  1  downstream accepts; a word transfers when validOut && readyOut.

Behaviour:
- Reset (async, active-high) values:
  - validOut=0, outData=0, outCount=0, readyIn=1.
  - Internal accumulator=0, byte counter=0, accFull=0.
- Storage is two stages:
  - The accumulator (acc, cnt 0..7, accFull).
  - The output holding register, which drives the outputs.
- Byte accept:
  - The byte is written to acc lane (WORD_BYTES-1-cnt), i.e. MSB-first.
  - cnt increments; when cnt reaches 8 the word is complete.
- Word completion on edge N:
  - If the holding register is empty, or drains on edge N (validOut && readyOut), the word moves to it.
  - The outputs then show validOut=1, outCount=8 from edge N (1-cycle latency from the 8th byte).
  - acc clears and cnt=0.
  - Otherwise the word stays in acc with accFull=1.
- readyIn = !accFull:
  - While accFull, no bytes are accepted.
  - accFull clears on the edge the holding register drains; the acc word moves across on that same edge.
- Holding register:
  - Clears validOut on drain unless it is reloaded on the same edge.
  - Back-to-back full words at one byte per cycle are sustainable at readyOut=1.
- Flush with cnt>0 and !accFull:
  - The partial word is emitted under the same move rule; unused low lanes are 0 and outCount=cnt.
  - If the holding register is occupied and not draining, the flush is remembered (pendFlush) and completes when the register drains.
  - readyIn=0 while pendFlush.
- Flush with a byte accepted the same cycle: the byte is packed first, then the flush applies.
  - If that byte is the 8th, the output is one full word with outCount=8 and nothing extra.
- Flush with cnt=0 and no byte: ignored, no output.
- Flush while accFull: ignored; the full word already pending covers it.
- Output stability: outData/outCount are stable while validOut && !readyOut.
- Reset mid-word: the partial accumulator and any held word are discarded without output.

Decomposition:
- Shared package (packer_pkg):
  - BYTE_W and WORD_BYTES constants.
  - Derived WORD_W and CNT_W.
  - A word_t typedef.
- Natural sub-module: out_skid_reg, the one-entry valid/ready holding register with load/drain.
- All packing and counting logic stays in word_packer.

Test Plan:
- Reset, then bytes 11,22,33,44,55,66,77,88 on consecutive cycles with readyOut=1 -> one cycle after the 8th byte, validOut=1, outData=64'h1122334455667788, outCount=8, for exactly one cycle.
- 16 consecutive bytes 0x00..0x0F with readyOut=1 -> words 64'h0001020304050607 then 64'h08090A0B0C0D0E0F, 8 cycles apart; readyIn stays 1 throughout.
- Bytes AA,BB,CC, then flush -> validOut=1, outData=64'hAABBCC0000000000, outCount=3. A following flush with no bytes produces no output.
- readyOut=0 while 16 bytes are offered:
  - The first word is held stable and the second fills acc.
  - readyIn falls to 0 after the 16th byte.
  - Raising readyOut drains both words in order on consecutive cycles, and readyIn returns to 1.
- Byte 0x99 as the 8th byte with flush in the same cycle -> a single word ending ...99 with outCount=8 and no extra partial word.
- Reset asserted mid-word after 5 bytes, then 8 new bytes 0xF0..0xF7 -> validOut=0 during reset; only 64'hF0F1F2F3F4F5F6F7 is emitted.
